exp_taylor_core: RTL



---
 rtl/exp_core_pkg.sv | 44 ++++
 rtl/exp_taylor_core_if.sv | 23 ++
 rtl/exp_recip_rom.sv | 11 +
 rtl/exp_taylor_core.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/exp_core_pkg.sv
// rtl/exp_core_pkg.sv - states, Q-format constants and reciprocal table for the e^x core
package exp_core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      MUL_X,
      MUL_R,
      ACC,
      ERR,
      DONE
   } state_e;

   localparam int FRAC_IN  = 12;
   localparam int FRAC_ACC = 16;
   localparam int ACC_W    = 36;
   localparam logic [ACC_W-1:0] ONE_Q16 = 36'h1_0000;
   localparam logic [15:0] LIMIT_DEFAULT = 16'h2000;

   // floor(65536/n); n = 0 never reaches the multiplier
   function automatic logic [16:0] recip_lut(input logic [3:0] n);
      logic [16:0] r;
      case (n)
         4'd1:    r = 17'd65536;
         4'd2:    r = 17'd32768;
         4'd3:    r = 17'd21845;
         4'd4:    r = 17'd16384;
         4'd5:    r = 17'd13107;
         4'd6:    r = 17'd10922;
         4'd7:    r = 17'd9362;
         4'd8:    r = 17'd8192;
         4'd9:    r = 17'd7281;
         4'd10:   r = 17'd6553;
         4'd11:   r = 17'd5957;
         4'd12:   r = 17'd5461;
         4'd13:   r = 17'd5041;
         4'd14:   r = 17'd4681;
         4'd15:   r = 17'd4369;
         default: r = 17'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exp_taylor_core_if.sv
// rtl/exp_taylor_core_if.sv - argument/result handshake bundle of the e^x core
interface exp_taylor_core_if;

   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_err;
   logic        busy;

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_result, out_err, busy
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_result, out_err, busy
   );

endinterface

// File: rtl/exp_recip_rom.sv
// rtl/exp_recip_rom.sv - combinational 1/n lookup in Q0.16
module exp_recip_rom
   import exp_core_pkg::*;
(
   input  logic [3:0]  n_i,
   output logic [16:0] recip_o
);

   assign recip_o = recip_lut(n_i);

endmodule

// File: rtl/exp_taylor_core.sv
// rtl/exp_taylor_core.sv - iterative Taylor-series e^x engine with one shared multiplier
module exp_taylor_core
   import exp_core_pkg::*;
#(
   parameter int          N_TERMS = 10,
   parameter logic [15:0] LIMIT   = LIMIT_DEFAULT
) (
   input logic              S_AXI_ACLK,
   input logic              S_AXI_ARESET,
   exp_taylor_core_if.slave bus
);

   state_e                   state_q, state_d;
   logic [15:0]              x_q, x_d;
   logic signed [ACC_W-1:0]  term_q, term_d;
   logic signed [ACC_W-1:0]  sum_q, sum_d;
   logic signed [ACC_W-1:0]  p_q, p_d;
   logic [3:0]               n_q, n_d;
   logic                     out_valid_q, out_valid_d;
   logic [31:0]              out_result_q, out_result_d;
   logic                     out_err_q, out_err_d;

   logic [16:0]              recip;
   logic signed [ACC_W-1:0]  mul_a;
   logic signed [17:0]       mul_b;
   logic signed [ACC_W+17:0] mul_p;
   logic signed [16:0]       x_ext, lim_pos, lim_neg;
   logic                     out_of_range;
   logic [31:0]              clamp;

   exp_recip_rom u_recip (
      .n_i     (n_q),
      .recip_o (recip)
   );

   // MUL_X scales term by x; MUL_R scales the partial product by 1/n
   always_comb begin
      if (state_q == MUL_R) begin
         mul_a = p_q;
         mul_b = $signed({1'b0, recip});
      end else begin
         mul_a = term_q;
         mul_b = $signed({{2{x_q[15]}}, x_q});
      end
   end

   assign mul_p = mul_a * mul_b;

   assign x_ext        = $signed({x_q[15], x_q});
   assign lim_pos      = $signed({1'b0, LIMIT});
   assign lim_neg      = -lim_pos;
   assign out_of_range = (x_ext > lim_pos) || (x_ext < lim_neg);

   always_comb begin
      if (sum_q[ACC_W-1])
         clamp = 32'h0;
      else if (|sum_q[ACC_W-2:32])
         clamp = 32'hFFFF_FFFF;
      else
         clamp = sum_q[31:0];
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state_q      <= IDLE;
         x_q          <= '0;
         term_q       <= '0;
         sum_q        <= '0;
         p_q          <= '0;
         n_q          <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         term_q       <= term_d;
         sum_q        <= sum_d;
         p_q          <= p_d;
         n_q          <= n_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_err_q    <= out_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      term_d       = term_q;
      sum_d        = sum_q;
      p_d          = p_q;
      n_d          = n_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_err_d    = out_err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               state_d = INIT;
            end
         end
         INIT: begin
            if (out_of_range) begin
               state_d = ERR;
            end else begin
               sum_d   = ONE_Q16;
               term_d  = ONE_Q16;
               n_d     = 4'd1;
               state_d = MUL_X;
            end
         end
         MUL_X: begin
            p_d     = ACC_W'(mul_p >>> FRAC_IN);
            state_d = MUL_R;
         end
         MUL_R: begin
            term_d  = ACC_W'(mul_p >>> FRAC_ACC);
            state_d = ACC;
         end
         ACC: begin
            sum_d   = sum_q + term_q;
            n_d     = n_q + 4'd1;
            state_d = (n_q == 4'(N_TERMS)) ? DONE : MUL_X;
         end
         ERR: begin
            out_result_d = 32'h0;
            out_err_d    = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            // normal path arrives with out_valid low: register the settled sum first
            if (!out_valid_q) begin
               out_result_d = clamp;
               out_err_d    = 1'b0;
               out_valid_d  = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_err    = out_err_q;

endmodule
